mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- MEM pipeline stage: sits between the EXE/MEM register and MEM_WB.
- Decodes ALU_Res into a data-memory word index and performs word loads/stores against an internal register-array data memory with a parameterised number of wait states.
- Freezes the upstream pipeline until the access completes.
- Presents the result (DataMemory, ALU_Res, Dest, WB_EN, MEM_R_EN, pc) to MEM_WB, inserting bubbles while stalled.

Parameters:
- DEPTH, 64: data memory depth in 32-bit words; power of two.
- BASE_ADDR, 1024: byte address mapped to word 0.
- WAIT_CYCLES, 2: stall cycles per memory access; 0 means single-cycle access.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- WB_EN  in  1  write-back enable from EXE/MEM
- MEM_R_EN  in  1  load request
- MEM_W_EN  in  1  store request
- ALU_Res  in  32  byte address, or non-memory result
- Val_Rm  in  32  store data
- Dest  in  4  destination register
- pc  in  32  instruction pc
- mem_ready  out  1  access complete / no access pending
- freeze  out  1  ~mem_ready; holds PC, IF/ID, ID/EX, EXE/MEM
- DataMemory  out  32  load data
- ALU_Res_out  out  32  ALU_Res passthrough
- Dest_out  out  4  Dest passthrough
- WB_EN_out  out  1  WB_EN gated by mem_ready
- MEM_R_EN_out  out  1  MEM_R_EN gated by mem_ready
- pc_out  out  32  pc passthrough
- mem_err  out  1  sticky address error (see Optional Feature)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Request definition: req = MEM_R_EN | MEM_W_EN.
- Word index: idx = (ALU_Res - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
- FSM states: IDLE, WAIT. Wait counter cnt is log2(WAIT_CYCLES+1) bits (minimum 1).
- IDLE:
  - No req: mem_ready=1.
  - req with WAIT_CYCLES=0: mem_ready=1, access performed this cycle, stay IDLE.
  - req with WAIT_CYCLES>0: mem_ready=0, next state WAIT, cnt<=1.
- WAIT:
  - cnt<WAIT_CYCLES: mem_ready=0, cnt<=cnt+1.
  - cnt==WAIT_CYCLES: mem_ready=1, access performed, next state IDLE, cnt<=0.
- Stall length: exactly WAIT_CYCLES stall cycles per access. Upstream holds all inputs stable while freeze=1. Inputs changing mid-WAIT is illegal; the access uses the values present in the completion cycle.
- Load: DataMemory = mem[idx], an asynchronous array read, valid in the completion cycle. DataMemory=0 whenever the cycle is not a completing load.
- Store: mem[idx] <= Val_Rm at the clock edge ending the completion cycle. A read of the same index in that cycle returns the old value.
- MEM_R_EN and MEM_W_EN both set: treated as a store only; DataMemory=0, MEM_R_EN_out=0.
- Passthroughs: ALU_Res_out, Dest_out and pc_out are combinational passthroughs.
- Bubbles: WB_EN_out = WB_EN & mem_ready and MEM_R_EN_out = MEM_R_EN & mem_ready, so MEM_WB captures a bubble each stall cycle.
- Back-to-back requests: the next instruction's req is seen in IDLE the cycle after completion and incurs its own stall. No zero-gap merging.
- Reset:
  - state<=IDLE, cnt<=0, mem_err<=0.
  - With inputs idle, outputs are mem_ready=1, freeze=0, DataMemory=0, WB_EN_out=0 (given WB_EN=0).
  - Memory array contents are not cleared.
  - A store in progress when rst asserts is abandoned and never written. This includes rst in the completion cycle: rst has priority over the write.

Optional Feature:
- Macro: MEM_ACCESS_ERR_EN.
- Defined:
  - Error condition: at access completion, ALU_Res<BASE_ADDR, or ALU_Res>=BASE_ADDR+4*DEPTH, or ALU_Res[1:0]!=0.
  - On error, mem_err<=1 (sticky until rst), the store is suppressed, and DataMemory=0.
  - Timing is unchanged.
- Not defined: index wraps modulo DEPTH, low two bits are ignored, mem_err tied 0.

Test Plan:
- Reset then idle, WAIT_CYCLES=2 -> mem_ready=1, freeze=0, DataMemory=0, WB_EN_out=0.
- Store 0xDEADBEEF at 1028, then load 1028, each held during its stall -> each op: freeze=1 for exactly 2 cycles, WB_EN_out=0 on those cycles; load completion cycle shows DataMemory=0xDEADBEEF, MEM_R_EN_out=1.
- Non-memory op (WB_EN=1, ALU_Res=5, Dest=3) -> no stall, WB_EN_out=1, ALU_Res_out=5, Dest_out=3, DataMemory=0.
- WAIT_CYCLES=0, store 7 at 1024 then immediate load 1024 on the next cycle -> never freezes, load returns 7.
- rst asserted in the first WAIT cycle of a store of 0x55 to 1032, then load 1032 -> state IDLE after reset, load returns the prior contents (not 0x55).
- MEM_ACCESS_ERR_EN defined, load at 1026, then store at 2000 -> mem_err rises at the first completion and stays 1, no write occurs, DataMemory=0.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM pipeline stage controller.
// It decodes ALU_Res into a data-memory word index. It performs word loads
// and stores against an internal register-array memory with WAIT_CYCLES stall
// cycles per access. It freezes upstream while an access is pending and
// drives MEM_WB with bubbles during a stall.
//
// Handshake: freeze (= ~mem_ready) is the only flow control. While freeze=1,
// upstream holds every input stable. The access takes effect only in the
// cycle where a request is present and mem_ready=1 (the completion cycle).
// MEM_WB captures the outputs on every clock edge. WB_EN_out and MEM_R_EN_out
// are forced low while mem_ready=0, so each stall cycle becomes a bubble.
//
// Optional build macro: MEM_ACCESS_ERR_EN
//   defined   : out-of-range or misaligned accesses set a sticky mem_err.
//               The store is dropped and DataMemory reads as 0.
//   undefined : the index wraps modulo DEPTH, the low address bits are
//               ignored, and mem_err stays 0.
module mem_stage_ctrl #(
  parameter int DEPTH       = 64,    // words, power of two, >= 2
  parameter int BASE_ADDR   = 1024,  // byte address of word 0
  parameter int WAIT_CYCLES = 2      // stall cycles per access
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_Rm,
  input  logic [3:0]  Dest,
  input  logic [31:0] pc,
  output logic        mem_ready,
  output logic        freeze,
  output logic [31:0] DataMemory,
  output logic [31:0] ALU_Res_out,
  output logic [3:0]  Dest_out,
  output logic        WB_EN_out,
  output logic        MEM_R_EN_out,
  output logic [31:0] pc_out,
  output logic        mem_err,
  output logic        dbg_state   // FSM state for checkers: 0=IDLE, 1=WAIT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);
  localparam logic [31:0]   BASE     = 32'(BASE_ADDR);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_err_q, mem_err_d;
  logic [31:0]   mem_q [DEPTH];

  logic          req;
  logic          is_load;
  logic          is_store;
  logic          complete;
  logic          addr_err;
  logic          mem_we;
  logic [AW-1:0] idx;

  // A request with both enables set is treated purely as a store.
  assign req      = MEM_R_EN | MEM_W_EN;
  assign is_store = MEM_W_EN;
  assign is_load  = MEM_R_EN & ~MEM_W_EN;
  assign idx      = AW'((ALU_Res - BASE) >> 2);

`ifdef MEM_ACCESS_ERR_EN
  localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(4 * DEPTH);
  // Address range and alignment check, evaluated on the completing access.
  assign addr_err = ({1'b0, ALU_Res} < {1'b0, BASE}) ||
                    ({1'b0, ALU_Res} >= LIMIT) ||
                    (ALU_Res[1:0] != 2'b00);
`else
  assign addr_err = 1'b0;
`endif

  // Next state, wait counter and access strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_ready = 1'b1;
    complete  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
          end else begin
            mem_ready = 1'b0;
            state_d   = S_WAIT;
            cnt_d     = CW'(1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          complete = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end else begin
          mem_ready = 1'b0;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Memory write strobe and sticky error. Reset wins over a completing store.
  always_comb begin
    mem_we    = complete & is_store & ~addr_err & ~rst;
    mem_err_d = mem_err_q | (complete & addr_err);
  end

  // Stage outputs: load data, passthroughs and bubble gating.
  always_comb begin
    DataMemory   = '0;
    if (complete && is_load && !addr_err) begin
      DataMemory = mem_q[idx];
    end
    freeze       = ~mem_ready;
    ALU_Res_out  = ALU_Res;
    Dest_out     = Dest;
    pc_out       = pc;
    WB_EN_out    = WB_EN & mem_ready;
    MEM_R_EN_out = MEM_R_EN & ~MEM_W_EN & mem_ready;
    mem_err      = mem_err_q;
    dbg_state    = state_q;
  end

  // State, counter and error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Data memory array; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= Val_Rm;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl. It drives two instances, u_a with
// WAIT_CYCLES=2 and u_b with WAIT_CYCLES=0. Drivers push the expected
// completion record for each operation into a queue. A monitor per instance
// checks stall cycles and pops and compares a record on every cycle where a
// request or write-back is presented with mem_ready=1.
module tb_mem_stage_ctrl;

  typedef struct packed {
    logic [31:0] dm;
    logic [31:0] alu;
    logic [3:0]  dest;
    logic [31:0] pc;
    logic        wb;
    logic        mr;
    logic [7:0]  stall;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- instance a (WAIT_CYCLES=2) ----------------
  logic        a_wb, a_mr, a_mw;
  logic [31:0] a_alu, a_val, a_pc;
  logic [3:0]  a_dest;
  logic        a_ready, a_freeze, a_wb_o, a_mr_o, a_err, a_state;
  logic [31:0] a_dm, a_alu_o, a_pc_o;
  logic [3:0]  a_dest_o;

  mem_stage_ctrl #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .WB_EN(a_wb), .MEM_R_EN(a_mr), .MEM_W_EN(a_mw),
    .ALU_Res(a_alu), .Val_Rm(a_val), .Dest(a_dest), .pc(a_pc),
    .mem_ready(a_ready), .freeze(a_freeze), .DataMemory(a_dm),
    .ALU_Res_out(a_alu_o), .Dest_out(a_dest_o), .WB_EN_out(a_wb_o),
    .MEM_R_EN_out(a_mr_o), .pc_out(a_pc_o), .mem_err(a_err),
    .dbg_state(a_state)
  );

  // ---------------- instance b (WAIT_CYCLES=0) ----------------
  logic        b_wb, b_mr, b_mw;
  logic [31:0] b_alu, b_val, b_pc;
  logic [3:0]  b_dest;
  logic        b_ready, b_freeze, b_wb_o, b_mr_o, b_err, b_state;
  logic [31:0] b_dm, b_alu_o, b_pc_o;
  logic [3:0]  b_dest_o;

  mem_stage_ctrl #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .WB_EN(b_wb), .MEM_R_EN(b_mr), .MEM_W_EN(b_mw),
    .ALU_Res(b_alu), .Val_Rm(b_val), .Dest(b_dest), .pc(b_pc),
    .mem_ready(b_ready), .freeze(b_freeze), .DataMemory(b_dm),
    .ALU_Res_out(b_alu_o), .Dest_out(b_dest_o), .WB_EN_out(b_wb_o),
    .MEM_R_EN_out(b_mr_o), .pc_out(b_pc_o), .mem_err(b_err),
    .dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  exp_t exp_qa[$];
  exp_t exp_qb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   stall_a      = 0;
  int   stall_b      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_out(input string tag, input exp_t e, input logic [31:0] dm,
                             input logic [31:0] alu, input logic [3:0] dest,
                             input logic [31:0] pcv, input logic wb, input logic mr,
                             input int stall);
    check({tag, "_dm"},    dm,            e.dm);
    check({tag, "_alu"},   alu,           e.alu);
    check({tag, "_dest"},  32'(dest),     32'(e.dest));
    check({tag, "_pc"},    pcv,           e.pc);
    check({tag, "_wb"},    32'(wb),       32'(e.wb));
    check({tag, "_mr"},    32'(mr),       32'(e.mr));
    check({tag, "_stall"}, 32'(stall),    32'(e.stall));
  endtask

  task automatic report_extra(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: got output with empty expected queue, required none", name);
  endtask

  // Monitor for instance a.
  always @(negedge clk) begin
    if (rst) begin
      stall_a = 0;
    end else if (!a_ready) begin
      stall_a++;
      check("a_stall_freeze", 32'(a_freeze), 32'd1);
      check("a_stall_bubble", {30'd0, a_wb_o, a_mr_o}, 32'd0);
    end else if (a_wb | a_mr | a_mw) begin
      if (exp_qa.size() == 0) report_extra("a_unexpected");
      else compare_out("a", exp_qa.pop_front(), a_dm, a_alu_o, a_dest_o, a_pc_o,
                       a_wb_o, a_mr_o, stall_a);
      stall_a = 0;
    end else begin
      check("a_idle", {a_dm[31:2], a_freeze, a_wb_o}, 32'd0);
    end
  end

  // Monitor for instance b.
  always @(negedge clk) begin
    if (rst) begin
      stall_b = 0;
    end else if (!b_ready) begin
      stall_b++;
      check("b_stall_freeze", 32'(b_freeze), 32'd1);
    end else if (b_wb | b_mr | b_mw) begin
      if (exp_qb.size() == 0) report_extra("b_unexpected");
      else compare_out("b", exp_qb.pop_front(), b_dm, b_alu_o, b_dest_o, b_pc_o,
                       b_wb_o, b_mr_o, stall_b);
      stall_b = 0;
    end else begin
      check("b_idle", {b_dm[31:2], b_freeze, b_wb_o}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_a(input logic wb, r, w, input logic [31:0] alu, val,
                       input logic [3:0] dest, input logic [31:0] pcv);
    a_wb = wb; a_mr = r; a_mw = w; a_alu = alu; a_val = val; a_dest = dest; a_pc = pcv;
  endtask

  task automatic set_b(input logic wb, r, w, input logic [31:0] alu, val,
                       input logic [3:0] dest, input logic [31:0] pcv);
    b_wb = wb; b_mr = r; b_mw = w; b_alu = alu; b_val = val; b_dest = dest; b_pc = pcv;
  endtask

  // Wait (bounded) until the selected instance shows mem_ready at a negedge.
  task automatic wait_ready(input bit inst);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if ((inst ? b_ready : a_ready) === 1'b1) break;
      n++;
      if (n > 20) begin
        tests_run++;
        tests_failed++;
        $display("FAIL wait_ready_%0d: got no mem_ready within 20 cycles, required ready", inst);
        break;
      end
    end
  endtask

  // Issue one operation, hold it until completion, then release after the edge.
  task automatic issue(input bit inst, input logic wb, r, w, input logic [31:0] alu, val,
                       input logic [3:0] dest, input logic [31:0] pcv,
                       input logic [31:0] exp_dm, input logic exp_mr, input int exp_stall);
    exp_t e;
    e = '{dm: exp_dm, alu: alu, dest: dest, pc: pcv, wb: wb, mr: exp_mr,
          stall: 8'(exp_stall)};
    if (!inst) begin
      set_a(wb, r, w, alu, val, dest, pcv);
      exp_qa.push_back(e);
    end else begin
      set_b(wb, r, w, alu, val, dest, pcv);
      exp_qb.push_back(e);
    end
    wait_ready(inst);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    set_a(0, 0, 0, 32'd0, 32'd0, 4'd0, 32'd0);
    set_b(0, 0, 0, 32'd0, 32'd0, 4'd0, 32'd0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    set_a(0, 0, 0, 32'd0, 32'd0, 4'd0, 32'd0);
    set_b(0, 0, 0, 32'd0, 32'd0, 4'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state with idle inputs.
    @(negedge clk);
    check("rst_ready",  32'(a_ready),  32'd1);
    check("rst_freeze", 32'(a_freeze), 32'd0);
    check("rst_dm",     a_dm,          32'd0);
    check("rst_wb_out", 32'(a_wb_o),   32'd0);
    check("rst_state",  32'(a_state),  32'd0);
    check("rst_err",    32'(a_err),    32'd0);
    @(posedge clk); #1;

    // Store then back-to-back load, WAIT_CYCLES=2.
    issue(0, 0, 0, 1, 32'd1028, 32'hDEADBEEF, 4'd0, 32'h100, 32'd0, 0, 2);
    issue(0, 1, 1, 0, 32'd1028, 32'd0,        4'd5, 32'h104, 32'hDEADBEEF, 1, 2);

    // Non-memory op passes straight through.
    issue(0, 1, 0, 0, 32'd5, 32'd0, 4'd3, 32'h108, 32'd0, 0, 0);

    // Both enables set acts as a store only.
    issue(0, 1, 1, 1, 32'd1036, 32'h12345678, 4'd6, 32'h10C, 32'd0, 0, 2);
    issue(0, 1, 1, 0, 32'd1036, 32'd0,        4'd7, 32'h110, 32'h12345678, 1, 2);
    idle_cycles(1);

    // WAIT_CYCLES=0: store 7 at 1024 and an immediate load, never frozen.
    issue(1, 0, 0, 1, 32'd1024, 32'd7, 4'd0, 32'h200, 32'd0, 0, 0);
    issue(1, 1, 1, 0, 32'd1024, 32'd0, 4'd2, 32'h204, 32'd7, 1, 0);
    issue(1, 1, 0, 0, 32'd9,    32'd0, 4'd4, 32'h208, 32'd0, 0, 0);
    idle_cycles(1);

    // Reset abandons a store in the first WAIT cycle.
    issue(0, 0, 0, 1, 32'd1032, 32'h11111111, 4'd0, 32'h300, 32'd0, 0, 2);
    set_a(0, 0, 1, 32'd1032, 32'h55, 4'd0, 32'h304);
    @(posedge clk); #1;
    check("pre_rst_state", 32'(a_state), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_state", 32'(a_state), 32'd0);
    idle_cycles(1);
    issue(0, 1, 1, 0, 32'd1032, 32'd0, 4'd8, 32'h308, 32'h11111111, 1, 2);

    // Reset in the completion cycle has priority over the write.
    set_a(0, 0, 1, 32'd1032, 32'h66, 4'd0, 32'h30C);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst2_state", 32'(a_state), 32'd0);
    idle_cycles(1);
    issue(0, 1, 1, 0, 32'd1032, 32'd0, 4'd9, 32'h310, 32'h11111111, 1, 2);
    idle_cycles(1);

`ifdef MEM_ACCESS_ERR_EN
    // Error build: misaligned load, then out-of-range store, both suppressed.
    issue(0, 0, 0, 1, 32'd1232, 32'hA5A5A5A5, 4'd0, 32'h400, 32'd0, 0, 2);
    check("err_clear", 32'(a_err), 32'd0);
    issue(0, 1, 1, 0, 32'd1026, 32'd0, 4'd1, 32'h404, 32'd0, 1, 2);
    check("err_set", 32'(a_err), 32'd1);
    issue(0, 0, 0, 1, 32'd2000, 32'hFFFFFFFF, 4'd0, 32'h408, 32'd0, 0, 2);
    check("err_sticky", 32'(a_err), 32'd1);
    issue(0, 1, 1, 0, 32'd1232, 32'd0, 4'd2, 32'h40C, 32'hA5A5A5A5, 1, 2);
    check("err_still", 32'(a_err), 32'd1);
`else
    // Default build: index wraps (2000 -> word 52 -> 1232), mem_err stays 0.
    issue(0, 0, 0, 1, 32'd2000, 32'hFFFFFFFF, 4'd0, 32'h400, 32'd0, 0, 2);
    issue(0, 1, 1, 0, 32'd1232, 32'd0, 4'd2, 32'h404, 32'hFFFFFFFF, 1, 2);
    check("no_err", 32'(a_err), 32'd0);
`endif
    check("b_no_err", 32'(b_err), 32'd0);

    idle_cycles(3);
    check("qa_drained", 32'(exp_qa.size()), 32'd0);
    check("qb_drained", 32'(exp_qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
